// File: rtl/poly_sndgen.sv
// Time-multiplexed polyphonic tone generator. On each sample_ena frame, one shared
// multiplier scans every voice in turn, and the voices are mixed into one saturated sample.
module poly_sndgen #(
    parameter int         NUM_CH    = 4,
    parameter int         PHASE_W   = 14,
    parameter int         VOL_W     = 4,
    parameter int         ENV_W     = 4,
    parameter int         ENV_DIV   = 6,
    parameter int         OUT_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hcf
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic                                           sample_ena,
    input  logic                                           cfg_valid,
    output logic                                           cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [PHASE_W-1:0]                             cfg_inc,
    input  logic [1:0]                                     cfg_wave,
    input  logic [VOL_W-1:0]                               cfg_vol,
    input  logic                                           cfg_gate,
    output logic [OUT_W-1:0]                               sample,
    output logic                                           sample_valid,
    output logic                                           busy,
    output logic [7:0]                                     overrun_cnt
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W  = 4 + $clog2(NUM_CH) + 1;
    localparam int PROD_W = 4 + VOL_W + ENV_W;
    localparam int DIV_W  = (ENV_DIV > 0) ? ENV_DIV : 1;
    localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q;
    logic [CH_W-1:0]    ch_idx_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [OUT_W-1:0]   sample_q, sample_d;
    logic               sample_valid_q;
    logic               busy_q;
    logic [7:0]         overrun_q;

    logic [PHASE_W-1:0] inc_q   [NUM_CH];
    logic [1:0]         wave_q  [NUM_CH];
    logic [VOL_W-1:0]   vol_q   [NUM_CH];
    logic               gate_q  [NUM_CH];
    logic [PHASE_W-1:0] phase_q [NUM_CH];
    logic [ENV_W-1:0]   env_q   [NUM_CH];

    logic [3:0]         w_s;
    logic [PROD_W-1:0]  prod_s;
    logic [3:0]         contrib_s;
    logic [PHASE_W-1:0] phase_d;
    logic [ENV_W-1:0]   env_d;
    logic [SAT_W-1:0]   acc_ext_s;
    logic               last_s;
    logic               cfg_hit_s;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        lfsr_step = cur[7] ? ({cur[6:0], 1'b1} ^ 8'h0d) : {cur[6:0], 1'b0};
    endfunction

    assign last_s    = (ch_idx_q == LAST_CH);
    assign cfg_hit_s = cfg_valid && !busy_q && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign div_d     = (ENV_DIV == 0) ? {DIV_W{1'b0}} : div_q + DIV_W'(1);

    // Datapath for the voice under scan: waveform, shared multiply, mix, phase and envelope step
    always_comb begin
        w_s = 4'd0;
        case (wave_q[ch_idx_q])
            2'd0:    w_s = {4{phase_q[ch_idx_q][PHASE_W-1]}};
            2'd1:    w_s = phase_q[ch_idx_q][PHASE_W-1 -: 4];
            2'd2:    w_s = lfsr_q[3:0];
            default: w_s = 4'd0;
        endcase
        prod_s    = PROD_W'(w_s) * PROD_W'(vol_q[ch_idx_q]) * PROD_W'(env_q[ch_idx_q]);
        contrib_s = 4'(prod_s >> (VOL_W + ENV_W));
        acc_d     = acc_q + ACC_W'(contrib_s);
        phase_d   = phase_q[ch_idx_q] + inc_q[ch_idx_q];
        env_d     = env_q[ch_idx_q];
        if (div_q == {DIV_W{1'b0}}) begin
            if (gate_q[ch_idx_q] && (env_q[ch_idx_q] != ENV_MAX)) begin
                env_d = env_q[ch_idx_q] + ENV_W'(1);
            end else if (!gate_q[ch_idx_q] && (env_q[ch_idx_q] != {ENV_W{1'b0}})) begin
                env_d = env_q[ch_idx_q] - ENV_W'(1);
            end else begin
                env_d = env_q[ch_idx_q];
            end
        end else begin
            env_d = env_q[ch_idx_q];
        end
        acc_ext_s = SAT_W'(acc_d);
        sample_d  = (acc_ext_s > SAT_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : acc_ext_s[OUT_W-1:0];
    end

    // Frame FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = sample_ena ? SCAN : IDLE;
            SCAN:    state_d = last_s ? OUT : SCAN;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame control, mix accumulator, output sample and overrun counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lfsr_q         <= LFSR_SEED;
            ch_idx_q       <= {CH_W{1'b0}};
            acc_q          <= {ACC_W{1'b0}};
            div_q          <= {DIV_W{1'b0}};
            sample_q       <= {OUT_W{1'b0}};
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_step(lfsr_q);
            busy_q         <= (state_d != IDLE);
            sample_valid_q <= (state_q == SCAN) && last_s;
            if (state_q == SCAN) begin
                ch_idx_q <= ch_idx_q + CH_W'(1);
                acc_q    <= acc_d;
            end else begin
                ch_idx_q <= {CH_W{1'b0}};
                acc_q    <= {ACC_W{1'b0}};
            end
            if ((state_q == SCAN) && last_s) begin
                sample_q <= sample_d;
            end
            if (state_q == OUT) begin
                div_q <= div_d;
            end
            if (sample_ena && busy_q && (overrun_q != 8'hff)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    // Per-voice registers: host writes while idle, phase/envelope stepping while scanning
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i]   <= {PHASE_W{1'b0}};
                wave_q[i]  <= 2'd0;
                vol_q[i]   <= {VOL_W{1'b0}};
                gate_q[i]  <= 1'b0;
                phase_q[i] <= {PHASE_W{1'b0}};
                env_q[i]   <= {ENV_W{1'b0}};
            end
        end else if (cfg_hit_s) begin
            inc_q[cfg_ch]  <= cfg_inc;
            wave_q[cfg_ch] <= cfg_wave;
            vol_q[cfg_ch]  <= cfg_vol;
            gate_q[cfg_ch] <= cfg_gate;
            if (cfg_gate && !gate_q[cfg_ch]) begin
                phase_q[cfg_ch] <= {PHASE_W{1'b0}};
            end
        end else if (state_q == SCAN) begin
            phase_q[ch_idx_q] <= phase_d;
            env_q[ch_idx_q]   <= env_d;
        end
    end

    assign cfg_ready    = ~busy_q;
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign overrun_cnt  = overrun_q;
endmodule

// File: tb/tb_poly_sndgen.sv
// Bench for poly_sndgen: two instances (4 voices/8-bit/ENV_DIV 0 and 3 voices/4-bit/ENV_DIV 1)
// share stimulus; a frame model feeds per-instance scoreboards checked on sample_valid.
module tb_poly_sndgen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0, sample_ena = 1'b0, cfg_valid = 1'b0, cfg_gate = 1'b0;
    logic [1:0] cfg_ch = 2'd0, cfg_wave = 2'd0;
    logic [13:0] cfg_inc = 14'd0;
    logic [3:0] cfg_vol = 4'd0;
    logic       ready_a, busy_a, valid_a, ready_b, busy_b, valid_b;
    logic [7:0] sample_a, ovr_a, ovr_b;
    logic [3:0] sample_b;

    always #5 clk = ~clk;

    poly_sndgen #(.NUM_CH(4), .ENV_DIV(0), .OUT_W(8)) dut_a (
        .clock(clk), .reset_n(reset_n), .sample_ena(sample_ena), .cfg_valid(cfg_valid),
        .cfg_ready(ready_a), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_wave(cfg_wave),
        .cfg_vol(cfg_vol), .cfg_gate(cfg_gate), .sample(sample_a), .sample_valid(valid_a),
        .busy(busy_a), .overrun_cnt(ovr_a));

    poly_sndgen #(.NUM_CH(3), .ENV_DIV(1), .OUT_W(4)) dut_b (
        .clock(clk), .reset_n(reset_n), .sample_ena(sample_ena), .cfg_valid(cfg_valid),
        .cfg_ready(ready_b), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_wave(cfg_wave),
        .cfg_vol(cfg_vol), .cfg_gate(cfg_gate), .sample(sample_b), .sample_valid(valid_b),
        .busy(busy_b), .overrun_cnt(ovr_b));

    typedef struct { int smp; int at; } exp_t;
    typedef struct { int ch; int inc; int wave; int vol; int frames; int exp_a; int exp_b; } vec_t;

    exp_t q_a[$], q_b[$];
    int   m_inc[2][4], m_wave[2][4], m_vol[2][4], m_gate[2][4], m_phase[2][4], m_env[2][4];
    int   m_div[2], m_ovr[2], b_lo[2], b_hi[2];
    int   cyc = 0, mlfsr = 0, tests = 0, fails = 0;
    bit   mon_en = 1'b0;

    function automatic int nch(input int k);  return (k == 0) ? 4 : 3;   endfunction
    function automatic int omax(input int k); return (k == 0) ? 255 : 15; endfunction
    function automatic int ediv(input int k); return (k == 0) ? 0 : 1;   endfunction
    function automatic bit m_busy(input int k); return (cyc >= b_lo[k]) && (cyc <= b_hi[k]); endfunction

    function automatic int lstep(input int l);
        if ((l & 32'h80) != 0) return (((l << 1) | 1) & 32'hff) ^ 32'h0d;
        else return (l << 1) & 32'hff;
    endfunction

    function automatic logic [31:0] g_smp(input int k);   return (k == 0) ? 32'(sample_a) : 32'(sample_b); endfunction
    function automatic logic [31:0] g_valid(input int k); return (k == 0) ? 32'(valid_a) : 32'(valid_b); endfunction
    function automatic logic [31:0] g_busy(input int k);  return (k == 0) ? 32'(busy_a) : 32'(busy_b); endfunction
    function automatic logic [31:0] g_ready(input int k); return (k == 0) ? 32'(ready_a) : 32'(ready_b); endfunction
    function automatic logic [31:0] g_ovr(input int k);   return (k == 0) ? 32'(ovr_a) : 32'(ovr_b); endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mlfsr <= !reset_n ? 32'hcf : lstep(mlfsr);
    end

    // Scoreboard monitor: busy/ready every cycle, sample value and latency on each sample_valid
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), g_busy(k), int'(m_busy(k)));
                chk($sformatf("cfg_ready%0d", k), g_ready(k), int'(!m_busy(k)));
                if (g_valid(k) === 32'd1) begin
                    if (((k == 0) ? q_a.size() : q_b.size()) == 0) begin
                        chk($sformatf("unexpected_valid%0d", k), g_valid(k), 0);
                    end else begin
                        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                        chk($sformatf("sample%0d", k), g_smp(k), e.smp);
                        chk($sformatf("valid_cycle%0d", k), 32'(cyc), e.at);
                    end
                end
            end
        end
    end

    task automatic model_frame(input int k, output int acc);
        int l, w;
        l = mlfsr;
        acc = 0;
        for (int i = 0; i < nch(k); i++) begin
            l = lstep(l);
            case (m_wave[k][i])
                0:       w = (((m_phase[k][i] >> 13) & 1) != 0) ? 15 : 0;
                1:       w = (m_phase[k][i] >> 10) & 15;
                2:       w = l & 15;
                default: w = 0;
            endcase
            acc += ((w * m_vol[k][i] * m_env[k][i]) >> 8) & 15;
            m_phase[k][i] = (m_phase[k][i] + m_inc[k][i]) % 16384;
            if (m_div[k] == 0) begin
                if (m_gate[k][i] != 0 && m_env[k][i] < 15) m_env[k][i]++;
                else if (m_gate[k][i] == 0 && m_env[k][i] > 0) m_env[k][i]--;
            end
        end
        m_div[k] = (m_div[k] + 1) % (1 << ediv(k));
    endtask

    task automatic book_ena();
        int   acc;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (m_busy(k)) begin
                if (m_ovr[k] < 255) m_ovr[k]++;
            end else begin
                model_frame(k, acc);
                e.smp = (acc > omax(k)) ? omax(k) : acc;
                e.at  = cyc + nch(k) + 1;
                if (k == 0) q_a.push_back(e); else q_b.push_back(e);
                b_lo[k] = cyc + 1;
                b_hi[k] = cyc + nch(k) + 1;
            end
        end
    endtask

    task automatic book_wr(input int ch, input int inc, input int wave, input int vol, input int gate);
        for (int k = 0; k < 2; k++) begin
            if (!m_busy(k) && ch < nch(k)) begin
                if (gate != 0 && m_gate[k][ch] == 0) m_phase[k][ch] = 0;
                m_inc[k][ch]  = inc;
                m_wave[k][ch] = wave;
                m_vol[k][ch]  = vol;
                m_gate[k][ch] = gate;
            end
        end
    endtask

    task automatic drive(input bit ena, input bit wr, input int ch, input int inc,
                         input int wave, input int vol, input int gate);
        cfg_valid  = wr;
        cfg_ch     = 2'(ch);
        cfg_inc    = 14'(inc);
        cfg_wave   = 2'(wave);
        cfg_vol    = 4'(vol);
        cfg_gate   = 1'(gate);
        sample_ena = ena;
        if (wr) book_wr(ch, inc, wave, vol, gate);
        if (ena) book_ena();
        @(negedge clk);
        cfg_valid  = 1'b0;
        sample_ena = 1'b0;
    endtask

    task automatic wr(input int ch, input int inc, input int wave, input int vol, input int gate);
        drive(1'b0, 1'b1, ch, inc, wave, vol, gate);
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (b_hi[k] > cyc) b_hi[k] = cyc;
            for (int i = 0; i < 4; i++) begin
                m_inc[k][i] = 0; m_wave[k][i] = 0; m_vol[k][i] = 0;
                m_gate[k][i] = 0; m_phase[k][i] = 0; m_env[k][i] = 0;
            end
            m_div[k] = 0;
            m_ovr[k] = 0;
        end
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_idle_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_sample%0d", tag, k), g_smp(k), 0);
            chk($sformatf("%s_valid%0d", tag, k), g_valid(k), 0);
            chk($sformatf("%s_busy%0d", tag, k), g_busy(k), 0);
            chk($sformatf("%s_ready%0d", tag, k), g_ready(k), 1);
            chk($sformatf("%s_ovr%0d", tag, k), g_ovr(k), 0);
        end
    endtask

    initial begin
        vec_t vt[5];
        vt[0] = '{0, 1024, 0, 15, 16, 13, 7};
        vt[1] = '{0, 1024, 0, 15, 24, 0, 0};
        vt[2] = '{1, 1024, 1, 15, 20, 2, 1};
        vt[3] = '{3, 8192, 0, 8, 12, 5, 0};
        vt[4] = '{0, 1024, 3, 15, 16, 0, 0};
        for (int k = 0; k < 2; k++) begin b_lo[k] = 0; b_hi[k] = -1; end

        repeat (2) @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        chk_idle_zero("reset");

        run_frames(2);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            wr(vt[v].ch, vt[v].inc, vt[v].wave, vt[v].vol, 1);
            run_frames(vt[v].frames);
            chk($sformatf("vec%0d_a", v), 32'(sample_a), vt[v].exp_a);
            chk($sformatf("vec%0d_b", v), 32'(sample_b), vt[v].exp_b);
        end

        // saw sweep with write in the sample_ena cycle, then release and decay, then noise
        do_reset();
        drive(1'b1, 1'b1, 0, 1024, 1, 15, 1);
        repeat (5) @(negedge clk);
        run_frames(31);
        chk("saw_peak_a", 32'(sample_a), 13);
        chk("saw_peak_b", 32'(sample_b), 13);
        wr(0, 1024, 1, 15, 0);
        run_frames(32);
        chk("decay_a", 32'(sample_a), 0);
        chk("decay_b", 32'(sample_b), 0);
        wr(1, 0, 2, 15, 1);
        run_frames(20);

        // all voices square-high at full volume and envelope
        do_reset();
        for (int c = 0; c < 4; c++) wr(c, 8192, 0, 15, 1);
        run_frames(32);
        chk("sat_a", 32'(sample_a), 52);
        chk("sat_b", 32'(sample_b), 15);

        // re-pulse inside a frame, then a continuous strobe to saturate the counter
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("overrun1_a", 32'(ovr_a), 1);
        chk("overrun1_b", 32'(ovr_b), 1);
        repeat (400) drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("overrun_sat_a", 32'(ovr_a), 255);
        chk("overrun_sat_b", 32'(ovr_b), 255);

        // reset during the scan aborts the frame
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        chk_idle_zero("midreset");
        repeat (8) @(negedge clk);

        // out-of-range voice on the 3-voice instance
        do_reset();
        wr(3, 8192, 0, 15, 1);
        run_frames(16);
        chk("ch3_a", 32'(sample_a), 13);
        chk("ch3_b", 32'(sample_b), 0);

        // gate held high keeps phase; gate 0->1 restarts phase
        do_reset();
        wr(2, 1024, 1, 15, 1);
        run_frames(5);
        wr(2, 1024, 1, 15, 1);
        run_frames(1);
        chk("gate_hold_a", 32'(sample_a), 1);
        wr(2, 1024, 1, 15, 0);
        wr(2, 1024, 1, 15, 1);
        run_frames(1);
        chk("retrig_a", 32'(sample_a), 0);
        chk("retrig_b", 32'(sample_b), 0);

        repeat (8) @(negedge clk);
        chk("pending_a", 32'(q_a.size()), 0);
        chk("pending_b", 32'(q_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
